// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, common command bytes
// and a sizing helper for the timeout counters.
package ps2_pkg;

    typedef enum logic [3:0] {
        IDLE,
        INHIBIT,
        RTS,
        DATA,
        PARITY,
        STOP,
        ACK,
        DONE,
        ERROR
    } state_t;

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_ACK      = 8'hFA;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizers for the PS/2 clock and data lines plus a one-cycle
// pulse on each falling edge of the synchronized clock.
module ps2_line_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic ps2_clk_i,
    input  logic ps2_dat_i,
    output logic dat_sync_o,
    output logic clk_negedge_o
);

    logic [1:0] clk_q;
    logic [1:0] dat_q;
    logic       clk_prev_q;

    // Idle bus level is high, so reset to 1 to avoid a false edge afterwards.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            clk_q      <= 2'b11;
            dat_q      <= 2'b11;
            clk_prev_q <= 1'b1;
        end else begin
            clk_q      <= {clk_q[0], ps2_clk_i};
            dat_q      <= {dat_q[0], ps2_dat_i};
            clk_prev_q <= clk_q[1];
        end
    end

    assign dat_sync_o    = dat_q[1];
    assign clk_negedge_o = clk_prev_q & ~clk_q[1];

endmodule

// File: rtl/ps2_command_out.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, device-clocked
// shifting of one command byte with odd parity, then ACK check with timeouts.
module ps2_command_out
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = 5050,
    parameter int unsigned START_TIMEOUT  = 750000,
    parameter int unsigned XFER_TIMEOUT   = 100000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [7:0] the_command,
    input  logic       send_command,
    output logic       command_was_sent,
    output logic       error_communication_timed_out,
    output logic       busy,
    inout  wire        PS2_CLK,
    inout  wire        PS2_DAT
);

    localparam int unsigned CNT_MAX = max3(INHIBIT_CYCLES, START_TIMEOUT, XFER_TIMEOUT);
    localparam int          CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);
    localparam logic [CNT_W-1:0] INH_LAST   = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] XFER_LAST  = CNT_W'(XFER_TIMEOUT - 1);

    state_t           state_q;
    logic [7:0]       cmd_q;
    logic             parity_q;
    logic [2:0]       idx_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             clk_low_q;
    logic             dat_low_q;
    logic             busy_q;
    logic             sent_q;
    logic             err_q;
    logic             dat_sync;
    logic             clk_negedge;

    ps2_line_sync u_sync (
        .clk_i        (CLOCK_50),
        .rst_i        (reset),
        .ps2_clk_i    (PS2_CLK),
        .ps2_dat_i    (PS2_DAT),
        .dat_sync_o   (dat_sync),
        .clk_negedge_o(clk_negedge)
    );

    // Saturating increment shared by the inhibit, start and transfer timers.
    assign cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + ONE;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q   <= IDLE;
            clk_low_q <= 1'b0;
            dat_low_q <= 1'b0;
            busy_q    <= 1'b0;
            sent_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: if (send_command) begin
                    cmd_q     <= the_command;
                    parity_q  <= ~^the_command;
                    cnt_q     <= '0;
                    clk_low_q <= 1'b1;
                    busy_q    <= 1'b1;
                    state_q   <= INHIBIT;
                end
                INHIBIT: if (cnt_q >= INH_LAST) begin
                    clk_low_q <= 1'b0;
                    dat_low_q <= 1'b1;
                    cnt_q     <= '0;
                    state_q   <= RTS;
                end else begin
                    cnt_q <= cnt_d;
                end
                RTS: if (clk_negedge) begin
                    dat_low_q <= ~cmd_q[0];
                    idx_q     <= 3'd0;
                    cnt_q     <= '0;
                    state_q   <= DATA;
                end else if (cnt_q >= START_LAST) begin
                    dat_low_q <= 1'b0;
                    err_q     <= 1'b1;
                    state_q   <= ERROR;
                end else begin
                    cnt_q <= cnt_d;
                end
                DATA, PARITY, STOP, ACK: begin
                    cnt_q <= cnt_d;
                    // An edge arriving on the timeout cycle takes precedence.
                    if (clk_negedge) begin
                        if (state_q == DATA) begin
                            if (idx_q == 3'd7) begin
                                dat_low_q <= ~parity_q;
                                state_q   <= PARITY;
                            end else begin
                                dat_low_q <= ~cmd_q[idx_q + 3'd1];
                                idx_q     <= idx_q + 3'd1;
                            end
                        end else if (state_q == PARITY) begin
                            dat_low_q <= 1'b0;
                            state_q   <= STOP;
                        end else if (state_q == STOP) begin
                            state_q <= ACK;
                        end else if (!dat_sync) begin
                            sent_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            err_q   <= 1'b1;
                            state_q <= ERROR;
                        end
                    end else if (cnt_q >= XFER_LAST) begin
                        dat_low_q <= 1'b0;
                        err_q     <= 1'b1;
                        state_q   <= ERROR;
                    end
                end
                DONE, ERROR: if (!send_command) begin
                    sent_q  <= 1'b0;
                    err_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign PS2_CLK = clk_low_q ? 1'b0 : 1'bz;
    assign PS2_DAT = dat_low_q ? 1'b0 : 1'bz;

    assign command_was_sent              = sent_q;
    assign error_communication_timed_out = err_q;
    assign busy                          = busy_q;

endmodule

// File: tb/tb_ps2_command_out.sv
// Scoreboarded bench for ps2_command_out with a device model that clocks the
// bus, captures each frame bit and optionally acknowledges.
module tb_ps2_command_out;

    localparam int INH  = 60;
    localparam int STO  = 1500;
    localparam int XTO  = 2000;
    localparam int HALF = 20;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] the_command;
    logic       send_command;
    logic       done, err, busy;
    logic       dev_clk_low, dev_dat_low;
    wire        ps2_clk, ps2_dat;

    pullup (ps2_clk);
    pullup (ps2_dat);
    assign ps2_clk = dev_clk_low ? 1'b0 : 1'bz;
    assign ps2_dat = dev_dat_low ? 1'b0 : 1'bz;

    ps2_command_out #(
        .INHIBIT_CYCLES(INH),
        .START_TIMEOUT (STO),
        .XFER_TIMEOUT  (XTO)
    ) dut (
        .CLOCK_50                     (clk),
        .reset                        (reset),
        .the_command                  (the_command),
        .send_command                 (send_command),
        .command_was_sent             (done),
        .error_communication_timed_out(err),
        .busy                         (busy),
        .PS2_CLK                      (ps2_clk),
        .PS2_DAT                      (ps2_dat)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [10:0] frame;
        bit          chk_frame;
        bit          done;
        bit          err;
    } exp_t;

    exp_t        q[$];
    exp_t        e;
    logic [10:0] cap_frame;
    int          n_vec = 0;
    int          n_miss = 0;
    logic        done_d = 1'b0, err_d = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every rising result flag retires the oldest expectation.
    always @(negedge clk) begin
        if (!reset && ((done && !done_d) || (err && !err_d))) begin
            if (q.size() == 0) begin
                chk("unexpected_flag", {30'd0, done, err}, 32'd0);
            end else begin
                e = q.pop_front();
                chk("result_flags", {30'd0, done, err}, {30'd0, e.done, e.err});
                if (e.chk_frame) chk("frame_bits", {21'd0, cap_frame}, {21'd0, e.frame});
            end
        end
        done_d = done;
        err_d  = err;
    end

    // Device: sample DAT while CLK is high, then pull CLK low for HALF cycles.
    task automatic dev_clock(input int nfalls, input bit ack);
        cap_frame = '0;
        for (int i = 0; i < nfalls; i++) begin
            repeat (HALF) @(negedge clk);
            if (i < 11) cap_frame[i] = ps2_dat;
            if (i == 11 && ack) begin
                dev_dat_low = 1'b1;
                repeat (4) @(negedge clk);
            end
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge clk);
            dev_clk_low = 1'b0;
        end
        dev_dat_low = 1'b0;
    endtask

    task automatic start_cmd(input logic [7:0] cmd, output int t_hi);
        int t0, t_low, n;
        @(negedge clk);
        the_command  = cmd;
        send_command = 1'b1;
        t0 = cyc;
        n = 0;
        do begin @(negedge clk); n++; end while (ps2_clk !== 1'b0 && n < 10);
        t_low = cyc;
        chk("accept_latency", t_low - t0, 1);
        chk("busy_in_frame", {31'd0, busy}, 1);
        n = 0;
        while (ps2_clk !== 1'b1 && n < INH + 50) begin @(negedge clk); n++; end
        t_hi = cyc;
        chk("inhibit_len", t_hi - t_low, INH);
        chk("start_bit_low", {31'd0, ps2_dat}, 0);
    endtask

    task automatic finish_frame(input logic [1:0] exp_flags);
        int n, lows;
        n = 0;
        while (!(done || err) && n < XTO + 100) begin @(negedge clk); n++; end
        if (!(done || err)) chk("result_wait_expired", 32'd0, 32'd1);
        lows = 0;
        repeat (20) begin
            @(negedge clk);
            if (ps2_clk === 1'b0) lows++;
        end
        chk("no_retrigger", lows, 0);
        chk("flag_held", {30'd0, done, err}, {30'd0, exp_flags});
        chk("lines_released", {30'd0, ps2_clk, ps2_dat}, 32'd3);
        send_command = 1'b0;
        @(negedge clk);
        chk("flag_clear", {29'd0, busy, done, err}, 32'd0);
    endtask

    task automatic run_frame(input logic [7:0] cmd, input logic par, input bit ack);
        exp_t x;
        int   t_hi;
        x.frame = {1'b1, par, cmd, 1'b0};
        x.chk_frame = 1'b1;
        x.done = ack;
        x.err  = !ack;
        q.push_back(x);
        start_cmd(cmd, t_hi);
        dev_clock(12, ack);
        finish_frame(ack ? 2'b10 : 2'b01);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected < 50000", cyc);
        $fatal(1);
    end

    initial begin
        exp_t x;
        int   t_hi, n;
        reset = 1'b1;
        send_command = 1'b0;
        the_command  = 8'h00;
        dev_clk_low  = 1'b0;
        dev_dat_low  = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_flags", {29'd0, busy, done, err}, 32'd0);
        chk("reset_lines", {30'd0, ps2_clk, ps2_dat}, 32'd3);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        run_frame(8'hED, 1'b1, 1'b1);
        run_frame(8'h01, 1'b0, 1'b1);
        run_frame(8'hFF, 1'b1, 1'b1);

        // Device never clocks after request-to-send.
        x.frame = '0; x.chk_frame = 1'b0; x.done = 1'b0; x.err = 1'b1;
        q.push_back(x);
        start_cmd(8'h55, t_hi);
        n = 0;
        while (!err && n < STO + 50) begin @(negedge clk); n++; end
        chk("start_timeout", cyc - t_hi, STO);
        finish_frame(2'b01);

        // Device clocks the whole frame but leaves DAT high in the ACK slot.
        run_frame(8'hA5, 1'b1, 1'b0);

        // Reset while bit 4 of 0xED (a 0) is on the line.
        start_cmd(8'hED, t_hi);
        dev_clock(5, 1'b0);
        chk("mid_frame_bit4", {31'd0, ps2_dat}, 0);
        reset = 1'b1;
        send_command = 1'b0;
        @(negedge clk);
        chk("midreset_busy", {29'd0, busy, done, err}, 32'd0);
        chk("midreset_lines", {30'd0, ps2_clk, ps2_dat}, 32'd3);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        run_frame(8'hF3, 1'b1, 1'b1);

        repeat (5) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
